// File: rtl/decode_unit.sv
// RV32I instruction decode stage: register selects, immediate, operand/ALU
// control, write enables and next-PC redirect. Only the start-up gate is clocked.
module decode_unit #(
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    branch,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    branch_op,
  output logic [31:0]             imm32,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic                    mem_wEn,
  output logic                    wb_sel
);

  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_t;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_PASS = 6'b011111;

  opcode_t                 opcode;
  logic [2:0]              funct3;
  logic                    started;
  logic                    enable;
  logic                    wen_dec;
  logic                    mem_wen_dec;
  logic                    redirect_dec;
  logic [ADDRESS_BITS-1:0] pc_plus4;
  logic [ADDRESS_BITS-1:0] pc_plus_imm;

  assign opcode      = opcode_t'(instruction[6:0]);
  assign funct3      = instruction[14:12];
  assign read_sel2   = instruction[24:20];
  assign write_sel   = instruction[11:7];
  assign pc_plus4    = PC + ADDRESS_BITS'(4);
  assign pc_plus_imm = PC + imm32[ADDRESS_BITS-1:0];

  // Side-effecting outputs stay quiet until the first clean edge after reset,
  // so a stale instruction word at start-up cannot write state or redirect fetch.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) started <= 1'b0;
    else       started <= 1'b1;
  end

  assign enable = started & ~reset;

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    imm32 = 32'd0;
    unique case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      OPC_STORE:
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instruction[31:12], 12'd0};
      OPC_JAL:
        imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    read_sel1    = instruction[19:15];
    wen_dec      = 1'b0;
    mem_wen_dec  = 1'b0;
    wb_sel       = 1'b0;
    op_A_sel     = 2'b00;
    op_B_sel     = 1'b0;
    branch_op    = 1'b0;
    ALU_Control  = 6'b000000;
    redirect_dec = 1'b0;
    target_PC    = pc_plus4;
    unique case (opcode)
      OPC_R: begin
        wen_dec     = 1'b1;
        ALU_Control = {2'b00, instruction[30], funct3};
      end
      OPC_OP_IMM: begin
        wen_dec     = 1'b1;
        op_B_sel    = 1'b1;
        // instr[30] is an immediate bit except for shifts, where it selects SRAI.
        ALU_Control = {2'b00, (funct3 == 3'b101) ? instruction[30] : 1'b0, funct3};
      end
      OPC_LOAD: begin
        wen_dec     = 1'b1;
        wb_sel      = 1'b1;
        op_B_sel    = 1'b1;
        ALU_Control = ALU_ADD;
      end
      OPC_STORE: begin
        mem_wen_dec = 1'b1;
        op_B_sel    = 1'b1;
        ALU_Control = ALU_ADD;
      end
      OPC_BRANCH: begin
        branch_op    = 1'b1;
        ALU_Control  = {3'b010, funct3};
        redirect_dec = branch;
        target_PC    = pc_plus_imm;
      end
      OPC_LUI: begin
        read_sel1   = 5'd0;
        wen_dec     = 1'b1;
        op_B_sel    = 1'b1;
        ALU_Control = ALU_ADD;
      end
      OPC_AUIPC: begin
        wen_dec     = 1'b1;
        op_A_sel    = 2'b01;
        op_B_sel    = 1'b1;
        ALU_Control = ALU_ADD;
      end
      OPC_JAL: begin
        wen_dec      = 1'b1;
        op_A_sel     = 2'b10;
        ALU_Control  = ALU_PASS;
        redirect_dec = 1'b1;
        target_PC    = pc_plus_imm;
      end
      OPC_JALR: begin
        wen_dec      = 1'b1;
        op_A_sel     = 2'b10;
        op_B_sel     = 1'b1;
        ALU_Control  = ALU_PASS;
        redirect_dec = 1'b1;
        target_PC    = {JALR_target[ADDRESS_BITS-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign wEn            = wen_dec      & enable;
  assign mem_wEn        = mem_wen_dec  & enable;
  assign next_PC_select = redirect_dec & enable;

endmodule

// File: tb/tb_decode_unit.sv
// Directed-vector bench for decode_unit: start-up gating, field extraction,
// immediates, control per opcode, ALU codes and next-PC targets.
module tb_decode_unit;

  localparam int AB = 16;

  logic          clock;
  logic          reset;
  logic [AB-1:0] PC;
  logic [31:0]   instruction;
  logic [AB-1:0] JALR_target;
  logic          branch;
  logic          next_PC_select;
  logic [AB-1:0] target_PC;
  logic [4:0]    read_sel1, read_sel2, write_sel;
  logic          wEn, branch_op, op_B_sel, mem_wEn, wb_sel;
  logic [31:0]   imm32;
  logic [1:0]    op_A_sel;
  logic [5:0]    ALU_Control;

  int n_vec  = 0;
  int n_miss = 0;

  decode_unit #(.ADDRESS_BITS(AB)) dut (
    .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
    .JALR_target(JALR_target), .branch(branch),
    .next_PC_select(next_PC_select), .target_PC(target_PC),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
    .wEn(wEn), .branch_op(branch_op), .imm32(imm32), .op_A_sel(op_A_sel),
    .op_B_sel(op_B_sel), .ALU_Control(ALU_Control), .mem_wEn(mem_wEn),
    .wb_sel(wb_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply(input logic [31:0] ins, input logic [AB-1:0] pc,
                       input logic [AB-1:0] jt, input logic br);
    instruction = ins;
    PC          = pc;
    JALR_target = jt;
    branch      = br;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    apply(32'h0000_0013, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    apply(32'hFFF0_0593, 16'h0000, 16'h0000, 1'b0);  // addi a1,zero,-1
    n_vec++; if (wEn !== 1'b0) begin n_miss++; $display("FAIL rst_wen: got %b want 0", wEn); end
    n_vec++; if (next_PC_select !== 1'b0) begin n_miss++; $display("FAIL rst_npc: got %b want 0", next_PC_select); end
    n_vec++; if (imm32 !== 32'hFFFF_FFFF) begin n_miss++; $display("FAIL rst_imm: got %h want ffffffff", imm32); end
    apply(32'h0140_006F, 16'h0114, 16'h0000, 1'b0);  // JAL under reset
    n_vec++; if (next_PC_select !== 1'b0) begin n_miss++; $display("FAIL rst_jal_npc: got %b want 0", next_PC_select); end
    n_vec++; if (target_PC !== 16'h0128) begin n_miss++; $display("FAIL rst_jal_tgt: got %h want 0128", target_PC); end
    apply(32'h00C5_A023, 16'h0000, 16'h0000, 1'b0);  // sw under reset
    n_vec++; if (mem_wEn !== 1'b0) begin n_miss++; $display("FAIL rst_memwen: got %b want 0", mem_wEn); end
    apply(32'hFFF0_0593, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
    #1;
    n_vec++; if (wEn !== 1'b0) begin n_miss++; $display("FAIL prestart_wen: got %b want 0", wEn); end
    @(posedge clock);
    #1;
    n_vec++; if (wEn !== 1'b1) begin n_miss++; $display("FAIL start_wen: got %b want 1", wEn); end
    n_vec++; if (read_sel1 !== 5'd0) begin n_miss++; $display("FAIL start_rs1: got %0d want 0", read_sel1); end
    n_vec++; if (write_sel !== 5'd11) begin n_miss++; $display("FAIL start_rd: got %0d want 11", write_sel); end
    n_vec++; if (op_B_sel !== 1'b1) begin n_miss++; $display("FAIL start_opb: got %b want 1", op_B_sel); end
    n_vec++; if (ALU_Control !== 6'b000000) begin n_miss++; $display("FAIL addi_neg_alu: got %b want 000000", ALU_Control); end
  endtask

  task automatic test_rtype;
    apply(32'h40E6_0833, 16'h0020, 16'h0000, 1'b1);  // sub x16,x12,x14
    n_vec++; if (ALU_Control !== 6'b001000) begin n_miss++; $display("FAIL sub_alu: got %b want 001000", ALU_Control); end
    n_vec++; if (read_sel1 !== 5'd12) begin n_miss++; $display("FAIL sub_rs1: got %0d want 12", read_sel1); end
    n_vec++; if (read_sel2 !== 5'd14) begin n_miss++; $display("FAIL sub_rs2: got %0d want 14", read_sel2); end
    n_vec++; if (write_sel !== 5'd16) begin n_miss++; $display("FAIL sub_rd: got %0d want 16", write_sel); end
    n_vec++; if (op_B_sel !== 1'b0) begin n_miss++; $display("FAIL sub_opb: got %b want 0", op_B_sel); end
    n_vec++; if (wEn !== 1'b1) begin n_miss++; $display("FAIL sub_wen: got %b want 1", wEn); end
    n_vec++; if (imm32 !== 32'd0) begin n_miss++; $display("FAIL sub_imm: got %h want 0", imm32); end
    n_vec++; if (next_PC_select !== 1'b0) begin n_miss++; $display("FAIL sub_br_ignored: got %b want 0", next_PC_select); end
    n_vec++; if (target_PC !== 16'h0024) begin n_miss++; $display("FAIL sub_tgt: got %h want 0024", target_PC); end
    apply(32'h00C5_8833, 16'h0024, 16'h0000, 1'b0);  // add x16,x11,x12
    n_vec++; if (ALU_Control !== 6'b000000) begin n_miss++; $display("FAIL add_alu: got %b want 000000", ALU_Control); end
    n_vec++; if (read_sel1 !== 5'd11) begin n_miss++; $display("FAIL add_rs1: got %0d want 11", read_sel1); end
  endtask

  task automatic test_mem;
    apply(32'h00C5_A023, 16'h0030, 16'h0000, 1'b0);  // sw a2,0(a1)
    n_vec++; if (mem_wEn !== 1'b1) begin n_miss++; $display("FAIL sw_memwen: got %b want 1", mem_wEn); end
    n_vec++; if (wEn !== 1'b0) begin n_miss++; $display("FAIL sw_wen: got %b want 0", wEn); end
    n_vec++; if (read_sel1 !== 5'd11) begin n_miss++; $display("FAIL sw_rs1: got %0d want 11", read_sel1); end
    n_vec++; if (read_sel2 !== 5'd12) begin n_miss++; $display("FAIL sw_rs2: got %0d want 12", read_sel2); end
    n_vec++; if (imm32 !== 32'd0) begin n_miss++; $display("FAIL sw_imm: got %h want 0", imm32); end
    n_vec++; if (ALU_Control !== 6'b000000) begin n_miss++; $display("FAIL sw_alu: got %b want 000000", ALU_Control); end
    apply(32'hFEC5_AC23, 16'h0030, 16'h0000, 1'b0);  // sw a2,-8(a1)
    n_vec++; if (imm32 !== 32'hFFFF_FFF8) begin n_miss++; $display("FAIL sw_neg_imm: got %h want fffffff8", imm32); end
    apply(32'h0005_A903, 16'h0034, 16'h0000, 1'b0);  // lw s2,0(a1)
    n_vec++; if (wb_sel !== 1'b1) begin n_miss++; $display("FAIL lw_wbsel: got %b want 1", wb_sel); end
    n_vec++; if (wEn !== 1'b1) begin n_miss++; $display("FAIL lw_wen: got %b want 1", wEn); end
    n_vec++; if (write_sel !== 5'd18) begin n_miss++; $display("FAIL lw_rd: got %0d want 18", write_sel); end
    n_vec++; if (mem_wEn !== 1'b0) begin n_miss++; $display("FAIL lw_memwen: got %b want 0", mem_wEn); end
  endtask

  task automatic test_jumps;
    apply(32'h0140_006F, 16'h0114, 16'h0000, 1'b0);  // jal x0,+20
    n_vec++; if (next_PC_select !== 1'b1) begin n_miss++; $display("FAIL jal_npc: got %b want 1", next_PC_select); end
    n_vec++; if (target_PC !== 16'h0128) begin n_miss++; $display("FAIL jal_tgt: got %h want 0128", target_PC); end
    n_vec++; if (op_A_sel !== 2'b10) begin n_miss++; $display("FAIL jal_opa: got %b want 10", op_A_sel); end
    n_vec++; if (ALU_Control !== 6'b011111) begin n_miss++; $display("FAIL jal_alu: got %b want 011111", ALU_Control); end
    n_vec++; if (imm32 !== 32'h0000_0014) begin n_miss++; $display("FAIL jal_imm: got %h want 00000014", imm32); end
    apply(32'hFFDF_F06F, 16'h0002, 16'h0000, 1'b0);  // jal x0,-4 wrapping below zero
    n_vec++; if (imm32 !== 32'hFFFF_FFFC) begin n_miss++; $display("FAIL jal_neg_imm: got %h want fffffffc", imm32); end
    n_vec++; if (target_PC !== 16'hFFFE) begin n_miss++; $display("FAIL jal_wrap_tgt: got %h want fffe", target_PC); end
    apply(32'h0C40_80E7, 16'h0094, 16'h0155, 1'b0);  // jalr ra,196(ra)
    n_vec++; if (target_PC !== 16'h0154) begin n_miss++; $display("FAIL jalr_tgt: got %h want 0154", target_PC); end
    n_vec++; if (imm32 !== 32'h0000_00C4) begin n_miss++; $display("FAIL jalr_imm: got %h want 000000c4", imm32); end
    n_vec++; if (read_sel1 !== 5'd1) begin n_miss++; $display("FAIL jalr_rs1: got %0d want 1", read_sel1); end
    n_vec++; if (write_sel !== 5'd1) begin n_miss++; $display("FAIL jalr_rd: got %0d want 1", write_sel); end
    n_vec++; if (next_PC_select !== 1'b1) begin n_miss++; $display("FAIL jalr_npc: got %b want 1", next_PC_select); end
    n_vec++; if (op_B_sel !== 1'b1) begin n_miss++; $display("FAIL jalr_opb: got %b want 1", op_B_sel); end
  endtask

  task automatic test_branch;
    apply(32'h00C6_8F63, 16'h0010, 16'h0000, 1'b0);  // beq a3,a2,+30
    n_vec++; if (next_PC_select !== 1'b0) begin n_miss++; $display("FAIL beq_nt_npc: got %b want 0", next_PC_select); end
    n_vec++; if (branch_op !== 1'b1) begin n_miss++; $display("FAIL beq_brop: got %b want 1", branch_op); end
    n_vec++; if (ALU_Control !== 6'b010000) begin n_miss++; $display("FAIL beq_alu: got %b want 010000", ALU_Control); end
    n_vec++; if (target_PC !== 16'h002E) begin n_miss++; $display("FAIL beq_tgt: got %h want 002e", target_PC); end
    n_vec++; if (wEn !== 1'b0) begin n_miss++; $display("FAIL beq_wen: got %b want 0", wEn); end
    n_vec++; if (read_sel1 !== 5'd13) begin n_miss++; $display("FAIL beq_rs1: got %0d want 13", read_sel1); end
    apply(32'h00C6_8F63, 16'h0010, 16'h0000, 1'b1);
    n_vec++; if (next_PC_select !== 1'b1) begin n_miss++; $display("FAIL beq_t_npc: got %b want 1", next_PC_select); end
    apply(32'h00C6_9F63, 16'h0010, 16'h0000, 1'b0);  // bne a3,a2,+30
    n_vec++; if (ALU_Control !== 6'b010001) begin n_miss++; $display("FAIL bne_alu: got %b want 010001", ALU_Control); end
  endtask

  task automatic test_utype_shift_illegal;
    apply(32'h000F_C617, 16'h0040, 16'h0000, 1'b0);  // auipc a2,252
    n_vec++; if (op_A_sel !== 2'b01) begin n_miss++; $display("FAIL auipc_opa: got %b want 01", op_A_sel); end
    n_vec++; if (imm32 !== 32'h000F_C000) begin n_miss++; $display("FAIL auipc_imm: got %h want 000fc000", imm32); end
    apply(32'h000F_C637, 16'h0040, 16'h0000, 1'b0);  // lui a2,252
    n_vec++; if (read_sel1 !== 5'd0) begin n_miss++; $display("FAIL lui_rs1: got %0d want 0", read_sel1); end
    n_vec++; if (op_A_sel !== 2'b00) begin n_miss++; $display("FAIL lui_opa: got %b want 00", op_A_sel); end
    n_vec++; if (wEn !== 1'b1) begin n_miss++; $display("FAIL lui_wen: got %b want 1", wEn); end
    apply(32'h4055_D593, 16'h0040, 16'h0000, 1'b0);  // srai a1,a1,5
    n_vec++; if (ALU_Control !== 6'b001101) begin n_miss++; $display("FAIL srai_alu: got %b want 001101", ALU_Control); end
    apply(32'h0055_D593, 16'h0040, 16'h0000, 1'b0);  // srli a1,a1,5
    n_vec++; if (ALU_Control !== 6'b000101) begin n_miss++; $display("FAIL srli_alu: got %b want 000101", ALU_Control); end
    apply(32'hFFFF_FFFF, 16'h0040, 16'h0000, 1'b1);  // opcode 1111111
    n_vec++; if ({wEn, mem_wEn, next_PC_select, branch_op} !== 4'b0000) begin
      n_miss++; $display("FAIL ill_en: got %b want 0000", {wEn, mem_wEn, next_PC_select, branch_op});
    end
    n_vec++; if (ALU_Control !== 6'b000000) begin n_miss++; $display("FAIL ill_alu: got %b want 000000", ALU_Control); end
    n_vec++; if (imm32 !== 32'd0) begin n_miss++; $display("FAIL ill_imm: got %h want 0", imm32); end
    n_vec++; if ({op_A_sel, op_B_sel} !== 3'b000) begin n_miss++; $display("FAIL ill_sel: got %b want 000", {op_A_sel, op_B_sel}); end
    apply(32'h0000_0013, 16'hFFFC, 16'h0000, 1'b0);  // nop at top of address space
    n_vec++; if (target_PC !== 16'h0000) begin n_miss++; $display("FAIL pc4_wrap: got %h want 0000", target_PC); end
  endtask

  task automatic test_async_reset;
    @(negedge clock);
    apply(32'h0140_006F, 16'h0114, 16'h0000, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (next_PC_select !== 1'b0) begin n_miss++; $display("FAIL async_rst_npc: got %b want 0", next_PC_select); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_vec++; if (next_PC_select !== 1'b0) begin n_miss++; $display("FAIL rerelease_npc: got %b want 0", next_PC_select); end
    @(posedge clock);
    #1;
    n_vec++; if (next_PC_select !== 1'b1) begin n_miss++; $display("FAIL restart_npc: got %b want 1", next_PC_select); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_jumps();
    test_branch();
    test_utype_shift_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
